// File: rtl/timestamp_bank_manager.sv
// Multi-frame live/shadow timestamp store: line-aligned bank swapping, frame sequencing
// by line count, and a sticky flag for writes aimed at a frame group that does not exist.
module timestamp_bank_manager #(
  parameter int unsigned NUM_FRAMES = 5,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned FRM_W      = 3
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              new_line_i,
  input  logic              mem_updated_i,
  input  logic [CNT_W-1:0]  mem_cycles_i,
  input  logic [CNT_W-1:0]  lines_per_frame_i,
  input  logic [FRM_W-1:0]  number_of_frames_i,
  input  logic              wen_i,
  input  logic [FRM_W-1:0]  wframe_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [TS_W:0]     wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              err_clr_i,
  output logic              update_mem_o,
  output logic              swap_o,
  output logic              swap_pending_o,
  output logic [FRM_W-1:0]  frame_o,
  output logic              active_pixel_o,
  output logic [TS_W-1:0]   timestamp_o,
  output logic              wr_err_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [FRM_W-1:0] LAST_FRAME = FRM_W'(NUM_FRAMES - 1);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [CNT_W-1:0]   line_cnt;
  logic [FRM_W-1:0]   frame_lim;
  logic               wr_bad;
  logic               wr_ok;

  logic [TS_W:0] mem [NUM_FRAMES][2][DEPTH];

  assign frame_lim = (number_of_frames_i > LAST_FRAME) ? LAST_FRAME : number_of_frames_i;
  assign wr_bad    = wen_i && ({1'b0, wframe_i} >= (FRM_W + 1)'(NUM_FRAMES));
  assign wr_ok     = wen_i && !wr_bad;

  // Swap FSM: a bank period ends on a line boundary; swap only once the shadow is complete.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state          <= ST_RUN;
      cyc_cnt        <= '0;
      update_mem_o   <= 1'b1;
      swap_o         <= 1'b0;
      swap_pending_o <= 1'b0;
    end else begin
      swap_o <= 1'b0;
      if (new_line_i) begin
        case (state)
          ST_RUN: begin
            if (cyc_cnt == mem_cycles_i) begin
              cyc_cnt <= '0;
              if (mem_updated_i) begin
                update_mem_o <= ~update_mem_o;
                swap_o       <= 1'b1;
              end else begin
                state          <= ST_WAIT;
                swap_pending_o <= 1'b1;
              end
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            if (mem_updated_i) begin
              update_mem_o   <= ~update_mem_o;
              swap_o         <= 1'b1;
              swap_pending_o <= 1'b0;
              state          <= ST_RUN;
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

  // Frame sequencer: advance one frame group every lines_per_frame_i+1 lines.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      line_cnt <= '0;
      frame_o  <= '0;
    end else if (new_line_i) begin
      if (line_cnt == lines_per_frame_i) begin
        line_cnt <= '0;
        frame_o  <= (frame_o >= frame_lim) ? '0 : frame_o + 1'b1;
      end else begin
        line_cnt <= line_cnt + 1'b1;
      end
    end
  end

  // Sticky error for writes to a non-existent frame group; a new error beats a clear.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_err_o <= 1'b0;
    end else if (wr_bad) begin
      wr_err_o <= 1'b1;
    end else if (err_clr_i) begin
      wr_err_o <= 1'b0;
    end
  end

  // Storage is intentionally not reset; writes always target the shadow bank.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wframe_i][update_mem_o][waddr_i] <= wdata_i;
    end
  end

  // Registered read from the live bank of the current frame group.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      active_pixel_o <= 1'b0;
      timestamp_o    <= '0;
    end else begin
      {active_pixel_o, timestamp_o} <= mem[frame_o][~update_mem_o][raddr_i];
    end
  end

endmodule

// File: tb/tb_timestamp_bank_manager.sv
// Bench for timestamp_bank_manager: a cycle model predicts control outputs and queues
// expected read words, which are compared when the registered read data appears.
module tb_timestamp_bank_manager;

  localparam int NF = 5;

  logic        clk = 1'b0;
  logic        nrst;
  logic        new_line, mem_updated;
  logic [7:0]  mem_cycles, lpf;
  logic [2:0]  nof, wframe;
  logic        wen, err_clr;
  logic [10:0] waddr, raddr;
  logic [16:0] wdata;
  logic        update_mem, swap, swap_pending, active_pixel, wr_err;
  logic [2:0]  frame;
  logic [15:0] timestamp;

  always #5 clk = ~clk;

  timestamp_bank_manager #(
    .NUM_FRAMES(5), .ADDR_W(11), .TS_W(16), .CNT_W(8), .FRM_W(3)
  ) dut (
    .clk_i(clk), .nrst_i(nrst), .new_line_i(new_line), .mem_updated_i(mem_updated),
    .mem_cycles_i(mem_cycles), .lines_per_frame_i(lpf), .number_of_frames_i(nof),
    .wen_i(wen), .wframe_i(wframe), .waddr_i(waddr), .wdata_i(wdata), .raddr_i(raddr),
    .err_clr_i(err_clr), .update_mem_o(update_mem), .swap_o(swap),
    .swap_pending_o(swap_pending), .frame_o(frame), .active_pixel_o(active_pixel),
    .timestamp_o(timestamp), .wr_err_o(wr_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  bit          m_wait, m_um, m_err, m_swap;
  int          m_cyc, m_line, m_frame;
  logic [16:0] m_mem [int];
  logic [16:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_wait = 0; m_um = 1; m_err = 0; m_swap = 0;
    m_cyc = 0; m_line = 0; m_frame = 0;
    sb_q.delete();
  endtask

  // One clock: predict from pre-edge state, advance, then compare.
  task automatic tick();
    bit          pushed;
    int          key, lim;
    logic [16:0] e;
    pushed = 0;
    key = m_frame * 4096 + (m_um ? 0 : 1) * 2048 + int'(raddr);
    if (m_mem.exists(key)) begin
      sb_q.push_back(m_mem[key]);
      pushed = 1;
    end
    if (wen && int'(wframe) < NF)
      m_mem[int'(wframe) * 4096 + (m_um ? 1 : 0) * 2048 + int'(waddr)] = wdata;
    if (wen && int'(wframe) >= NF) m_err = 1;
    else if (err_clr) m_err = 0;
    m_swap = 0;
    if (new_line) begin
      if (!m_wait) begin
        if (m_cyc == int'(mem_cycles)) begin
          m_cyc = 0;
          if (mem_updated) m_swap = 1;
          else m_wait = 1;
        end else m_cyc = (m_cyc + 1) % 256;
      end else if (mem_updated) begin
        m_swap = 1;
        m_wait = 0;
      end
      if (m_swap) m_um = !m_um;
      lim = (int'(nof) > NF - 1) ? NF - 1 : int'(nof);
      if (m_line == int'(lpf)) begin
        m_line  = 0;
        m_frame = (m_frame >= lim) ? 0 : m_frame + 1;
      end else m_line = (m_line + 1) % 256;
    end
    @(posedge clk);
    #1;
    if (pushed) begin
      e = sb_q.pop_front();
      check("rdata", 32'({active_pixel, timestamp}), 32'(e));
    end
    check("update_mem", 32'(update_mem), 32'(m_um));
    check("swap", 32'(swap), 32'(m_swap));
    check("swap_pending", 32'(swap_pending), 32'(m_wait));
    check("frame", 32'(frame), 32'(m_frame));
    check("wr_err", 32'(wr_err), 32'(m_err));
    new_line = 0; wen = 0; err_clr = 0;
  endtask

  task automatic line(input int idle);
    new_line = 1;
    tick();
    repeat (idle) tick();
  endtask

  task automatic wr(input int f, input int a, input logic [16:0] d);
    wen = 1; wframe = 3'(f); waddr = 11'(a); wdata = d;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 0;
    #1;
    model_reset();
    check("rst_update_mem", 32'(update_mem), 32'd1);
    check("rst_swap", 32'(swap), 32'd0);
    check("rst_pending", 32'(swap_pending), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_timestamp", 32'(timestamp), 32'd0);
    check("rst_active", 32'(active_pixel), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    @(negedge clk);
    nrst = 1;
  endtask

  initial begin
    nrst = 0; new_line = 0; mem_updated = 1; mem_cycles = 8'd0; lpf = 8'd200; nof = 3'd0;
    wen = 0; wframe = 0; waddr = 0; wdata = 0; raddr = 0; err_clr = 0;
    model_reset();
    do_reset();

    // populate both banks at addr 5 with known words
    wr(0, 5, 17'h0_5555);
    line(0);
    wr(0, 5, 17'h0_AAAA);
    line(0);

    // T2: write to shadow, old data visible until the third line swaps
    mem_cycles = 8'd2;
    wr(0, 5, 17'h1_00AB);
    raddr = 11'd5;
    tick();
    check("t2_old_data", 32'(timestamp), 32'h0000_AAAA);
    line(1);
    line(1);
    line(0);
    check("t2_swap_pulse", 32'(swap), 32'd1);
    check("t2_update_mem", 32'(update_mem), 32'd0);
    tick();
    check("t2_new_active", 32'(active_pixel), 32'd1);
    check("t2_new_ts", 32'(timestamp), 32'h0000_00AB);

    // T3: period expires without mem_updated -> pending until raised
    mem_updated = 0;
    line(1); line(1); line(1);
    check("t3_pending", 32'(swap_pending), 32'd1);
    for (int i = 0; i < 4; i++) begin
      line(1);
      check("t3_no_swap", 32'(update_mem), 32'd0);
    end
    mem_updated = 1;
    line(0);
    check("t3_swap", 32'(swap), 32'd1);
    check("t3_pending_clr", 32'(swap_pending), 32'd0);
    tick();

    // T5: out-of-range frame write is dropped and flagged
    mem_cycles = 8'd0;
    wr(5, 5, 17'h1_FFFF);
    check("t5_err_set", 32'(wr_err), 32'd1);
    tick();
    line(1);
    tick();
    err_clr = 1;
    tick();
    check("t5_err_clr", 32'(wr_err), 32'd0);
    wen = 1; wframe = 3'd7; waddr = 11'd5; wdata = 17'h1_FFFF; err_clr = 1;
    tick();
    check("t5_set_wins", 32'(wr_err), 32'd1);
    err_clr = 1;
    tick();

    // T6: write coincident with swap lands in the bank going live
    wr(0, 9, 17'h0_0777);
    line(0);
    raddr = 11'd9;
    wen = 1; wframe = 0; waddr = 11'd9; wdata = 17'h0_1234; new_line = 1;
    tick();
    check("t6_swap_edge_old", 32'(timestamp), 32'h0000_0777);
    tick();
    check("t6_after_swap", 32'(timestamp), 32'h0000_1234);

    // T4: frame sequencing after a reset that keeps memory
    do_reset();
    tick();
    lpf = 8'd3; nof = 3'd2; mem_cycles = 8'd7;
    for (int i = 1; i <= 12; i++) begin
      line(1);
      if (i == 4)  check("t4_frame1", 32'(frame), 32'd1);
      if (i == 8)  check("t4_frame2", 32'(frame), 32'd2);
      if (i == 12) check("t4_frame0", 32'(frame), 32'd0);
    end
    nof = 3'd7;
    for (int i = 1; i <= 20; i++) begin
      line(0);
      if (i == 16) check("t4_clamp_f4", 32'(frame), 32'd4);
      if (i == 20) check("t4_clamp_wrap", 32'(frame), 32'd0);
    end

    // mid-frame reset returns sequencer to frame 0
    nof = 3'd4;
    for (int i = 0; i < 5; i++) line(0);
    check("t6_pre_reset_frame", 32'(frame), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) line(0);
    check("t6_post_reset_frame", 32'(frame), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
